pulse_interval_meter: RTL
=========================

# pulse_interval_meter

Measures the number of clock cycles between a rising edge on a start pulse line and the next rising edge on a stop pulse line, such as the short- and long-period pulse outputs of the pulse generators. It sits directly downstream of those generators and presents each measurement to a consumer through a valid/ack handshake. A timeout and a saturating measurement counter are included. The block is single-clock and fully synchronous.

## Interface
- CNT_W, 8: width of the interval counter and result.
- TIMEOUT, 200: maximum interval in cycles. It must satisfy 1 ≤ TIMEOUT ≤ 2^CNT_W − 1.
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_pulse  input  1  start event line; only its rising edge matters.
- stop_pulse  input  1  stop event line; only its rising edge matters.
- result_ack  input  1  consumer accepts the held result.
- interval  output  CNT_W  measured cycles between the start edge and the stop edge.
- timeout  output  1  the held result ended by timeout rather than by a stop edge.
- result_valid  output  1  interval and timeout are valid and held.
- busy  output  1  a measurement is in progress.
- meas_count  output  8  number of completed non-timeout measurements, saturating at 255.

## Operation
- Rising edge detection: rise = in & ~in_q, where in_q is the input registered every cycle, including in HOLD.
  - in_q resets to 0, so an input already high in the first cycle after reset counts as an edge.
  - A line held high produces exactly one edge.
- The FSM has three states: IDLE, MEASURE, HOLD.
- IDLE:
  - On a start rise, load cnt ← 1 and go to MEASURE.
  - A stop rise in IDLE is ignored.
  - If start and stop rise in the same cycle, the start is taken and the stop is dropped.
- MEASURE:
  - On a stop rise: interval ← cnt, timeout ← 0, go to HOLD, and increment meas_count if it is below 255.
  - Otherwise, when cnt == TIMEOUT: interval ← TIMEOUT, timeout ← 1, go to HOLD. meas_count is unchanged.
  - Otherwise, cnt ← cnt + 1.
  - If a stop rise arrives in the same cycle as cnt == TIMEOUT, the stop wins and timeout = 0.
  - Start rises during MEASURE are ignored; a measurement is never restarted.
- HOLD:
  - result_valid = 1, and interval and timeout are stable.
  - When result_ack = 1, go to IDLE; result_valid is 0 from the next cycle.
  - All edges seen during HOLD, including in the ack cycle, are dropped.
- result_ack outside HOLD is ignored.
- Output decoding:
  - busy = (state == MEASURE).
  - result_valid = (state == HOLD).
  - interval and timeout keep their last value in IDLE and MEASURE until overwritten.
- Arithmetic: cnt is CNT_W bits wide and never exceeds TIMEOUT, so it cannot wrap.

## Timing
- Reset state: IDLE.
- Reset values: cnt = 0, in_q = 0, interval = 0, timeout = 0, result_valid = 0, busy = 0, meas_count = 0.
- Reset asserted in any state, including mid-MEASURE or HOLD, forces the reset values on the next edge. Any pending result is discarded.
- A start rise sampled at cycle t gives busy = 1 from t+1.
- A stop rise sampled at cycle t+k gives interval = k, and result_valid = 1 from t+k+1.
- Without a stop, the timeout result appears with result_valid = 1 at t+TIMEOUT+1.
- Ack sampled at cycle h: result_valid = 0 at h+1. The earliest new start rise that is accepted is sampled at h+1.
- Throughput: at most one measurement per k+2 cycles, for k ≥ 1 (each k-cycle measurement plus one HOLD cycle with immediate ack and one IDLE cycle).

## Structure
- Package pulse_meter_pkg holds:
  - the state enum (IDLE, MEASURE, HOLD);
  - the meas_count width (8) and its saturation value (255);
  - the default CNT_W and TIMEOUT.
- Sub-module rise_detect (clk, reset, in, rise) holds in_q and is instantiated once per input line.
- The FSM, interval counter, and result registers live in pulse_interval_meter.

## Test plan
- Generator-shaped stimulus: reset released, start high for one cycle 4 cycles after release, stop high for one cycle 19 cycles after release → interval = 15, timeout = 0, result_valid one cycle after the stop; after ack, meas_count = 1.
- Start rise with no stop (TIMEOUT = 200) → result_valid at start + 201, interval = 200, timeout = 1, meas_count unchanged.
- Start and stop rising together in IDLE → busy = 1 and no result. A stop 7 cycles later → interval = 7.
- Result held with ack low for 50 cycles while start and stop toggle → interval unchanged and state stays HOLD. After ack, the next start rise measures normally.
- Reset asserted mid-MEASURE (cnt = 9) → all outputs 0 next cycle. A start held high through reset release → exactly one edge, so one measurement starts.
- 300 back-to-back measurements of 3 cycles each, with immediate ack → meas_count saturates at 255. Every result reads interval = 3, timeout = 0.

Source files
------------

// File: rtl/pulse_interval_meter_pkg.sv
// Shared types and constants for the pulse interval meter.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        HOLD    = 2'd2
    } meter_state_t;

    localparam int MEAS_W      = 8;
    localparam int MEAS_SAT    = 255;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 200;

endpackage

// File: rtl/pulse_interval_meter_rise_detect.sv
// Rising-edge detector: one registered copy of the line, updated every cycle.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic r_in_q;

    // Delay the line by one cycle; reset clears it so a line already high counts as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_q <= 1'b0;
        end else begin
            r_in_q <= in;
        end
    end

    assign rise = in & ~r_in_q;

endmodule

// File: rtl/pulse_interval_meter.sv
// Measures cycles from a start-line rising edge to the next stop-line rising edge.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a start edge; stop edges are ignored
//   MEASURE | counting; ends on a stop edge or when the count hits TIMEOUT
//   HOLD    | result presented with result_valid until result_ack
module pulse_interval_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_pulse,
    input  logic              stop_pulse,
    input  logic              result_ack,
    output logic [CNT_W-1:0]  interval,
    output logic              timeout,
    output logic              result_valid,
    output logic              busy,
    output logic [MEAS_W-1:0] meas_count
);

    localparam logic [CNT_W-1:0]  TIMEOUT_V  = CNT_W'(TIMEOUT);
    localparam logic [MEAS_W-1:0] MEAS_SAT_V = MEAS_W'(MEAS_SAT);

    meter_state_t      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_interval;
    logic              r_timeout;
    logic [MEAS_W-1:0] r_meas_count;
    logic              w_start_rise;
    logic              w_stop_rise;

    rise_detect u_start_rise (
        .clk   (clk),
        .reset (reset),
        .in    (start_pulse),
        .rise  (w_start_rise)
    );

    rise_detect u_stop_rise (
        .clk   (clk),
        .reset (reset),
        .in    (stop_pulse),
        .rise  (w_stop_rise)
    );

    // Sequencing FSM with the interval counter and held result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_interval   <= '0;
            r_timeout    <= 1'b0;
            r_meas_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A stop edge coinciding with the start edge is simply dropped.
                    if (w_start_rise) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    // Stop edge has priority over the timeout in the same cycle.
                    if (w_stop_rise) begin
                        r_interval <= r_cnt;
                        r_timeout  <= 1'b0;
                        r_state    <= HOLD;
                        if (r_meas_count < MEAS_SAT_V) begin
                            r_meas_count <= r_meas_count + MEAS_W'(1);
                        end
                    end else if (r_cnt == TIMEOUT_V) begin
                        r_interval <= TIMEOUT_V;
                        r_timeout  <= 1'b1;
                        r_state    <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (result_ack) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_state == MEASURE);
    assign result_valid = (r_state == HOLD);
    assign interval     = r_interval;
    assign timeout      = r_timeout;
    assign meas_count   = r_meas_count;

endmodule
